// File: rtl/morse_symbol_classifier_if.sv
// Symbol-code link from the key sampler to the Morse receiver: tick/key in, 2-bit code, word_end and count out.
// Combinational bundle only, so it adds no latency and carries no backpressure (the link is paced by tick).
interface morse_symbol_classifier_if;
  logic       tick;
  logic       serial_inp;
  logic       parallel_out0;
  logic       parallel_out1;
  logic       word_end;
  logic [2:0] sym_cnt;

  modport master (
    output tick,
    output serial_inp,
    input  parallel_out0,
    input  parallel_out1,
    input  word_end,
    input  sym_cnt
  );

  modport slave (
    input  tick,
    input  serial_inp,
    output parallel_out0,
    output parallel_out1,
    output word_end,
    output sym_cnt
  );
endinterface

// File: rtl/morse_symbol_classifier.sv
// Times key marks/spaces in divider ticks and emits dot/dash/letter-end codes plus a word_end pulse.
// Codes appear on the first low tick sample (+2 clk sync) and hold one tick period; no backpressure, tick-paced.
module morse_symbol_classifier #(
  parameter int CNT_W      = 5,
  parameter int MIN_PULSE  = 2,
  parameter int DOT_MAX    = 4,
  parameter int LETTER_GAP = 6,
  parameter int WORD_GAP   = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  morse_symbol_classifier_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] code;
    logic       word_end;
    logic [2:0] sym_cnt;
  } out_t;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_DOT    = 2'b01;
  localparam logic [1:0] CODE_DASH   = 2'b11;
  localparam logic [1:0] CODE_LETTER = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] DOT_P      = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] LETTER_P   = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_P     = CNT_W'(WORD_GAP);
  localparam logic [2:0]       SYM_MAX    = 3'd7;

  logic [1:0]       sync_q;
  logic             key;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q,  gap_cnt_d;
  logic [CNT_W-1:0] gap_inc;
  logic             pending_q,  pending_d;
  out_t             out_q,      out_d;

  // serial_inp is asynchronous to clk; the sync runs every clk so it is settled before each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.serial_inp};
    end
  end

  assign key = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mark_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pending_q  <= 1'b0;
      out_q      <= '0;
    end else if (bus.tick) begin
      state_q    <= state_d;
      mark_cnt_q <= mark_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    mark_cnt_d       = mark_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    pending_d        = pending_q;
    out_d.code       = CODE_NONE;
    out_d.word_end   = 1'b0;
    out_d.sym_cnt    = out_q.sym_cnt;
    gap_inc          = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        if (key) begin
          state_d    = MARK;
          mark_cnt_d = CNT_ONE;
        end
      end

      MARK: begin
        if (key) begin
          // Saturate so a stuck key can never wrap back into the dot range.
          if (mark_cnt_q != CNT_MAX) begin
            mark_cnt_d = mark_cnt_q + CNT_ONE;
          end
        end else begin
          mark_cnt_d = '0;
          if (mark_cnt_q < MIN_P) begin
            // Glitch: resume timing the open letter's space, or drop back to idle.
            if (pending_q) begin
              state_d   = SPACE;
              gap_cnt_d = CNT_ONE;
            end else begin
              state_d   = IDLE;
              gap_cnt_d = '0;
            end
          end else begin
            out_d.code = (mark_cnt_q <= DOT_P) ? CODE_DOT : CODE_DASH;
            state_d    = SPACE;
            gap_cnt_d  = CNT_ONE;
            pending_d  = 1'b1;
            if (out_q.sym_cnt != SYM_MAX) begin
              out_d.sym_cnt = out_q.sym_cnt + 3'd1;
            end
          end
        end
      end

      SPACE: begin
        if (key) begin
          state_d    = MARK;
          mark_cnt_d = CNT_ONE;
        end else begin
          gap_cnt_d = gap_inc;
          if ((gap_inc == LETTER_P) && pending_q) begin
            out_d.code    = CODE_LETTER;
            out_d.sym_cnt = 3'd0;
            pending_d     = 1'b0;
          end
          if (gap_inc == WORD_P) begin
            out_d.word_end = 1'b1;
            state_d        = IDLE;
            gap_cnt_d      = '0;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        mark_cnt_d = '0;
        gap_cnt_d  = '0;
        pending_d  = 1'b0;
      end
    endcase
  end

  assign bus.parallel_out1 = out_q.code[1];
  assign bus.parallel_out0 = out_q.code[0];
  assign bus.word_end      = out_q.word_end;
  assign bus.sym_cnt       = out_q.sym_cnt;

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Randomized and directed bench for morse_symbol_classifier against a run-length reference model.
module tb_morse_symbol_classifier;
  localparam int CNT_W      = 5;
  localparam int MIN_PULSE  = 2;
  localparam int DOT_MAX    = 4;
  localparam int LETTER_GAP = 6;
  localparam int WORD_GAP   = 14;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  morse_symbol_classifier_if bus ();

  morse_symbol_classifier #(
    .CNT_W      (CNT_W),
    .MIN_PULSE  (MIN_PULSE),
    .DOT_MAX    (DOT_MAX),
    .LETTER_GAP (LETTER_GAP),
    .WORD_GAP   (WORD_GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int tick_no = 0;

  // Reference model state: run lengths of the sampled key, symbols in the open letter,
  // and whether the current silence is being timed towards letter/word end.
  int         ones_run;
  int         zeros_run;
  int         letter_syms;
  bit         space_live;
  logic [1:0] pe_code;
  logic       pe_we;
  int         pe_sym;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] ecode, input logic ewe, input int esym);
    check_eq($sformatf("%s.code", tag), 32'({bus.parallel_out1, bus.parallel_out0}), 32'(ecode));
    check_eq($sformatf("%s.word_end", tag), 32'(bus.word_end), 32'(ewe));
    check_eq($sformatf("%s.sym_cnt", tag), 32'(bus.sym_cnt), 32'(esym));
  endtask

  task automatic model_reset();
    ones_run    = 0;
    zeros_run   = 0;
    letter_syms = 0;
    space_live  = 1'b0;
    pe_code     = 2'b00;
    pe_we       = 1'b0;
    pe_sym      = 0;
  endtask

  // One tick period: present the key, let it cross the synchronizer, pulse tick, then compare.
  task automatic step(input bit key);
    logic [1:0] ecode;
    logic       ewe;
    @(negedge clk);
    bus.serial_inp = key;
    bus.tick       = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs($sformatf("t%0d.hold", tick_no), pe_code, pe_we, pe_sym);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;

    ecode = 2'b00;
    ewe   = 1'b0;
    if (key) begin
      ones_run++;
      zeros_run = 0;
    end else if (ones_run > 0) begin
      if (ones_run < MIN_PULSE) begin
        space_live = (letter_syms > 0);
      end else begin
        ecode = (ones_run <= DOT_MAX) ? 2'b01 : 2'b11;
        letter_syms++;
        space_live = 1'b1;
      end
      ones_run  = 0;
      zeros_run = 1;
    end else begin
      zeros_run++;
      if (space_live) begin
        if (zeros_run == LETTER_GAP && letter_syms > 0) begin
          ecode       = 2'b10;
          letter_syms = 0;
        end
        if (zeros_run == WORD_GAP) begin
          ewe        = 1'b1;
          space_live = 1'b0;
        end
      end
    end
    pe_code = ecode;
    pe_we   = ewe;
    pe_sym  = (letter_syms > 7) ? 7 : letter_syms;
    check_outputs($sformatf("t%0d", tick_no), pe_code, pe_we, pe_sym);
    tick_no++;
  endtask

  task automatic send(input int ones, input int zeros);
    for (int i = 0; i < ones; i++) step(1'b1);
    for (int i = 0; i < zeros; i++) step(1'b0);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs(tag, 2'b00, 1'b0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.tick       = 1'b0;
    bus.serial_inp = 1'b0;
    model_reset();

    // Reset held while the key and tick toggle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.serial_inp = ~bus.serial_inp;
      bus.tick       = i[0];
    end
    #1;
    check_outputs("in_reset", 2'b00, 1'b0, 0);
    @(negedge clk);
    bus.tick       = 1'b0;
    bus.serial_inp = 1'b0;
    rst            = 1'b1;

    send(0, 20);                 // quiet line after reset
    send(3, 6);                  // dot then letter end
    send(0, 10);
    send(5, 14);                 // dash, letter and word end
    send(34, 14);                // stuck key saturates, still a dash
    send(40, 14);
    send(1, 20);                 // glitch from idle
    send(3, 2);                  // glitch between symbols must not close the letter
    send(1, 3);
    send(3, 14);
    send(5, 2);                  // letter K
    send(3, 2);
    send(5, 14);
    send(3, 5);                  // rising key on the would-be letter-end tick
    send(3, 14);
    for (int i = 0; i < 9; i++) send(3, 2);  // sym_cnt saturation
    send(0, 14);
    send(3, 8);                  // glitch after the letter closed drops to idle
    send(1, 20);

    send(3, 1);                  // reset while a dot code is showing
    reset_pulse("rst_on_code");
    send(3, 0);                  // reset mid-mark discards it
    reset_pulse("rst_mid_mark");
    send(0, 10);

    for (int n = 0; n < 200; n++) begin
      int ones;
      int zeros;
      ones  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(28, 36)) : int'($urandom_range(0, 7));
      zeros = int'($urandom_range(1, 16));
      send(ones, zeros);
    end
    send(0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
